// File: rtl/status_word_encoder.sv
// status_word_encoder: builds the 16-bit host status word.
// Level inputs are re-registered every cycle. The done/err inputs are
// reduced to rising-edge events and held in sticky bits until the host
// reads them. An overflow bit records an event that landed on a sticky
// bit which was already set and not being cleared in that cycle.
//
// Read handshake: the host raises rd_req for one cycle per read, and may
// hold it high for back-to-back reads. At that same edge, status is
// loaded with a snapshot and rd_ack pulses high for one cycle. There is
// no backpressure, so every rd_req cycle is served.
module status_word_encoder #(
  parameter bit IRQ_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        running1,
  input  logic        running2,
  input  logic        done1,
  input  logic        done2,
  input  logic        err1,
  input  logic        err2,
  input  logic [1:0]  sync_locked,
  input  logic [1:0]  active_bank,
  input  logic        armed1,
  input  logic        armed2,
  input  logic [2:0]  mode,
  input  logic [3:0]  irq_mask,
  input  logic        rd_req,
  output logic [15:0] status,
  output logic        rd_ack,
  output logic        irq
);

  // Live fields packed in status-word order (low to high):
  // running1, running2, sync_locked, active_bank, armed1, armed2, mode.
  logic [10:0] live_q, live_d;
  logic [3:0]  prev_q;       // previous {err2, err1, done2, done1}
  logic [3:0]  sticky_q, sticky_d;
  logic        ovf_q, ovf_d;
  logic [15:0] status_q, status_d;
  logic        rd_ack_q;
  logic        irq_q, irq_d;
  logic [3:0]  ev_in;
  logic [3:0]  ev;
  logic [3:0]  clr;

  assign ev_in = {err2, err1, done2, done1};
  assign ev    = ev_in & ~prev_q;
  assign clr   = {4{rd_req}};

  // Next-state: sticky capture, overflow, snapshot and interrupt level.
  always_comb begin
    live_d   = {mode, armed2, armed1, active_bank, sync_locked, running2, running1};
    sticky_d = (sticky_q & ~clr) | ev;
    ovf_d    = (ovf_q & ~rd_req) | (|(ev & sticky_q & ~clr));
    status_d = status_q;
    if (rd_req) begin
      // Sticky and overflow values are taken before the clear, so an
      // event arriving in the read cycle is left for the next read.
      status_d = {ovf_q, live_q[10:6], live_q[5:2], sticky_q, live_q[1:0]};
    end
    irq_d = IRQ_EN & ((|(sticky_d & irq_mask)) | ovf_d);
  end

  // State registers; everything clears asynchronously on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live_q   <= '0;
      prev_q   <= '0;
      sticky_q <= '0;
      ovf_q    <= 1'b0;
      status_q <= '0;
      rd_ack_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      live_q   <= live_d;
      prev_q   <= ev_in;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
      status_q <= status_d;
      rd_ack_q <= rd_req;
      irq_q    <= irq_d;
    end
  end

  assign status = status_q;
  assign rd_ack = rd_ack_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_status_word_encoder.sv
// Bench for status_word_encoder: a per-edge reference model built on
// event counts since the last read, a per-cycle compare process, and
// directed scenarios that carry hand-computed literal expectations.
module tb_status_word_encoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        running1, running2, done1, done2, err1, err2;
  logic [1:0]  sync_locked, active_bank;
  logic        armed1, armed2;
  logic [2:0]  mode;
  logic [3:0]  irq_mask;
  logic        rd_req;
  logic [15:0] status, status_z;
  logic        rd_ack, rd_ack_z;
  logic        irq, irq_z;

  status_word_encoder #(.IRQ_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .running1(running1), .running2(running2),
    .done1(done1), .done2(done2), .err1(err1), .err2(err2),
    .sync_locked(sync_locked), .active_bank(active_bank),
    .armed1(armed1), .armed2(armed2), .mode(mode),
    .irq_mask(irq_mask), .rd_req(rd_req),
    .status(status), .rd_ack(rd_ack), .irq(irq)
  );

  status_word_encoder #(.IRQ_EN(1'b0)) dut_noirq (
    .clk(clk), .reset_n(reset_n),
    .running1(running1), .running2(running2),
    .done1(done1), .done2(done2), .err1(err1), .err2(err2),
    .sync_locked(sync_locked), .active_bank(active_bank),
    .armed1(armed1), .armed2(armed2), .mode(mode),
    .irq_mask(irq_mask), .rd_req(rd_req),
    .status(status_z), .rd_ack(rd_ack_z), .irq(irq_z)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending event counts per source since the last read; a bit is
  // reported while its count is nonzero, overflow means some count
  // reached two before a read.
  logic [15:0] exp_q[$];
  int          m_cnt[4];
  logic [3:0]  m_prev;
  logic [15:0] m_live;
  logic [15:0] m_status;
  logic        m_ack, m_irq, m_ovf;
  logic [3:0]  m_cur;
  logic [15:0] m_snap;

  function automatic logic [15:0] live_word();
    logic [15:0] w;
    w = 16'(running1) + 16'(running2) * 16'd2
      + 16'(sync_locked) * 16'd64 + 16'(active_bank) * 16'd256
      + 16'(armed1) * 16'd1024 + 16'(armed2) * 16'd2048
      + 16'(mode) * 16'd4096;
    return w;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_prev = '0; m_live = '0; m_status = '0;
      m_ack = 1'b0; m_irq = 1'b0; m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      m_cur = {err2, err1, done2, done1};
      if (rd_req) begin
        m_snap = m_live;
        for (int i = 0; i < 4; i++)
          if (m_cnt[i] > 0) m_snap = m_snap + (16'd4 << i);
        if (m_ovf) m_snap = m_snap + 16'h8000;
        m_status = m_snap;
        exp_q.push_back(m_snap);
        m_ack = 1'b1;
        m_ovf = 1'b0;
        for (int i = 0; i < 4; i++) m_cnt[i] = (m_cur[i] && !m_prev[i]) ? 1 : 0;
      end else begin
        m_ack = 1'b0;
        for (int i = 0; i < 4; i++)
          if (m_cur[i] && !m_prev[i]) begin
            m_cnt[i]++;
            if (m_cnt[i] > 1) m_ovf = 1'b1;
          end
      end
      m_prev = m_cur;
      m_live = live_word();
      m_irq  = m_ovf;
      for (int i = 0; i < 4; i++)
        if (m_cnt[i] > 0 && irq_mask[i]) m_irq = 1'b1;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    check("status", status, m_status);
    check("rd_ack", 16'(rd_ack), 16'(m_ack));
    check("irq", 16'(irq), 16'(m_irq));
    check("status_noirq", status_z, m_status);
    check("irq_noirq", 16'(irq_z), 16'd0);
    if (reset_n && m_ack) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL snapshot_queue: got empty queue, expected an entry at %0t", $time);
      end else begin
        check("snapshot", status, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic all_inputs(input logic v);
    running1 = v; running2 = v; done1 = v; done2 = v; err1 = v; err2 = v;
    sync_locked = {2{v}}; active_bank = {2{v}};
    armed1 = v; armed2 = v; mode = {3{v}};
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset_n = 1'b0;
    rd_req = 1'b0;
    irq_mask = 4'hF;
    all_inputs(1'b1);
    tick(); tick();
    check("reset_status", status, 16'h0000);
    check("reset_irq", 16'(irq), 16'd0);
    check("reset_ack", 16'(rd_ack), 16'd0);
    reset_n = 1'b1;
    tick();
    check("first_edge_irq", 16'(irq), 16'd1);
    do_read();
    check("reset_read", status, 16'h7FFF);
    check("reset_read_sticky", 16'(status[5:2]), 16'hF);
    all_inputs(1'b0);
    tick();
    do_read();
    tick();

    // Live fields.
    running1 = 1'b1; sync_locked = 2'b10; active_bank = 2'b01;
    armed2 = 1'b1; mode = 3'b101;
    tick(); tick();
    do_read();
    check("live_status", status, 16'h5981);
    check("live_ack_hi", 16'(rd_ack), 16'd1);
    tick();
    check("live_ack_lo", 16'(rd_ack), 16'd0);
    all_inputs(1'b0);
    tick();
    do_read();
    check("live_clear", status, 16'h0000);

    // Event / read collision.
    done1 = 1'b1; tick(); done1 = 1'b0; tick();
    do_read();
    check("coll_bit2", 16'(status[2]), 16'd1);
    done2 = 1'b1; rd_req = 1'b1;
    tick();
    rd_req = 1'b0; done2 = 1'b0;
    check("coll_bit3_excluded", 16'(status[3]), 16'd0);
    tick();
    do_read();
    check("coll_next_read", status, 16'h0008);

    // Overflow.
    err1 = 1'b1; tick(); err1 = 1'b0; tick();
    err1 = 1'b1; tick(); err1 = 1'b0; tick();
    check("ovf_irq", 16'(irq), 16'd1);
    do_read();
    check("ovf_read", status, 16'h8010);
    do_read();
    check("ovf_cleared", status, 16'h0000);

    // Interrupt masking.
    irq_mask = 4'h1;
    err2 = 1'b1; tick(); err2 = 1'b0; tick();
    check("mask_irq_low", 16'(irq), 16'd0);
    irq_mask = 4'h8;
    tick();
    check("mask_irq_high", 16'(irq), 16'd1);
    do_read();
    check("mask_read_err2", status, 16'h0020);
    check("mask_irq_cleared", 16'(irq), 16'd0);
    irq_mask = 4'hF;

    // Back-to-back reads with done1 toggling.
    tick();
    rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      done1 = (k % 2 == 0);
      tick();
      check("b2b_ack", 16'(rd_ack), 16'd1);
      check("b2b_bit2", 16'(status[2]), (k % 2 == 1) ? 16'd1 : 16'd0);
      check("b2b_bit15", 16'(status[15]), 16'd0);
    end
    rd_req = 1'b0; done1 = 1'b0;
    tick();
    check("b2b_ack_end", 16'(rd_ack), 16'd0);

    // Reset during a read.
    running1 = 1'b1;
    tick();
    do_read();
    check("midrst_before", status, 16'h0001);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_status", status, 16'h0000);
    check("midrst_ack", 16'(rd_ack), 16'd0);
    tick();
    reset_n = 1'b1;
    running1 = 1'b0;
    tick(); tick();
    do_read();
    check("post_rst_read", status, 16'h0000);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
